// File: rtl/batch_former.sv
`default_nettype none
// ============================================================================
// Module   : batch_former
// Purpose  : Gathers conflict-free transactions into batches and drains each
//            batch downstream with its union read/write dependency vectors.
// Revision : 1.0
// ============================================================================
module batch_former #(
    parameter int MAX_BATCH_SIZE = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic [63:0]                            s_axis_tdata_owner_programID,
    input  logic [1023:0]                          s_axis_tdata_read_dependencies,
    input  logic [1023:0]                          s_axis_tdata_write_dependencies,
    input  logic                                   batch_flush,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [63:0]                            m_axis_tdata_programID,
    output logic                                   m_axis_tlast,
    output logic [$clog2(MAX_BATCH_SIZE+1)-1:0]    m_axis_batch_size,
    output logic [1023:0]                          m_axis_batch_read_dependencies,
    output logic [1023:0]                          m_axis_batch_write_dependencies,
    output logic                                   batch_completed,
    output logic [31:0]                            batches_formed,
    output logic [31:0]                            batch_timeouts
);

    localparam int              C_CW  = $clog2(MAX_BATCH_SIZE + 1);
    localparam int              C_IW  = $clog2(MAX_BATCH_SIZE);
    localparam logic [C_CW-1:0] C_MAX = C_CW'(MAX_BATCH_SIZE);
    localparam logic [31:0]     C_TMO = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [63:0]       r_buf [MAX_BATCH_SIZE];
    logic [C_CW-1:0]   r_count;
    logic [C_IW-1:0]   r_rd_idx;
    logic [31:0]       r_timer;
    logic [1023:0]     r_union_rd;
    logic [1023:0]     r_union_wr;
    logic [31:0]       r_batches;
    logic [31:0]       r_timeouts;

    logic              w_collect;
    logic              w_drain;
    logic              w_accept;
    logic [C_CW-1:0]   w_count_acc;
    logic              w_full;
    logic              w_tmo;
    logic              w_flush;
    logic              w_close;
    logic              w_last;

    assign w_collect     = (r_state == COLLECT);
    assign w_drain       = (r_state == DRAIN);
    assign s_axis_tready = w_collect && (r_count < C_MAX);
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_count_acc   = r_count + C_CW'(w_accept);

    // Close conditions use the post-accept count so a same-cycle accept joins the batch.
    assign w_full  = w_accept && (w_count_acc == C_MAX);
    assign w_tmo   = (r_count != '0) && (r_timer == C_TMO);
    assign w_flush = batch_flush && (w_count_acc != '0);
    assign w_close = w_collect && (w_full || w_tmo || w_flush);
    assign w_last  = ((C_CW'(r_rd_idx) + C_CW'(1)) == r_count);

    always_comb begin
        w_state_next    = r_state;
        m_axis_tvalid   = 1'b0;
        batch_completed = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_close) w_state_next = DRAIN;
            end
            DRAIN: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready && w_last) w_state_next = DONE;
            end
            DONE: begin
                batch_completed = 1'b1;
                w_state_next    = COLLECT;
            end
            default: w_state_next = COLLECT;
        endcase
    end

    // Downstream data is forced to zero outside a drain so idle outputs match reset.
    assign m_axis_tdata_programID          = w_drain ? r_buf[r_rd_idx] : 64'd0;
    assign m_axis_tlast                    = w_drain && w_last;
    assign m_axis_batch_size               = w_drain ? r_count : '0;
    assign m_axis_batch_read_dependencies  = w_drain ? r_union_rd : '0;
    assign m_axis_batch_write_dependencies = w_drain ? r_union_wr : '0;
    assign batches_formed                  = r_batches;
    assign batch_timeouts                  = r_timeouts;

    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_count[C_IW-1:0]] <= s_axis_tdata_owner_programID;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_count    <= '0;
            r_rd_idx   <= '0;
            r_timer    <= '0;
            r_union_rd <= '0;
            r_union_wr <= '0;
            r_batches  <= '0;
            r_timeouts <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                COLLECT: begin
                    r_timer <= (r_count != '0) ? r_timer + 32'd1 : 32'd0;
                    if (w_accept) begin
                        r_count    <= w_count_acc;
                        r_union_rd <= r_union_rd | s_axis_tdata_read_dependencies;
                        r_union_wr <= r_union_wr | s_axis_tdata_write_dependencies;
                    end
                    if (w_close) r_rd_idx <= '0;
                    if (w_close && w_tmo && !w_full) r_timeouts <= r_timeouts + 32'd1;
                end
                DRAIN: begin
                    if (m_axis_tready) r_rd_idx <= r_rd_idx + C_IW'(1);
                end
                DONE: begin
                    r_count    <= '0;
                    r_timer    <= '0;
                    r_rd_idx   <= '0;
                    r_union_rd <= '0;
                    r_union_wr <= '0;
                    r_batches  <= r_batches + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_batch_former.sv
`default_nettype none
// ============================================================================
// Module   : tb_batch_former
// Purpose  : Directed self-checking bench for batch_former (MAX=16, TIMEOUT=256).
// Revision : 1.0
// ============================================================================
module tb_batch_former;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_tvalid;
    logic          s_tready;
    logic [63:0]   s_id;
    logic [1023:0] s_rd;
    logic [1023:0] s_wr;
    logic          flush;
    logic          m_tvalid;
    logic          m_tready;
    logic [63:0]   m_id;
    logic          m_tlast;
    logic [4:0]    m_size;
    logic [1023:0] m_rd;
    logic [1023:0] m_wr;
    logic          completed;
    logic [31:0]   formed;
    logic [31:0]   timeouts;

    int errors = 0;
    int checks = 0;

    batch_former #(.MAX_BATCH_SIZE(16), .TIMEOUT_CYCLES(256)) dut (
        .clk                             (clk),
        .rst                             (rst),
        .s_axis_tvalid                   (s_tvalid),
        .s_axis_tready                   (s_tready),
        .s_axis_tdata_owner_programID    (s_id),
        .s_axis_tdata_read_dependencies  (s_rd),
        .s_axis_tdata_write_dependencies (s_wr),
        .batch_flush                     (flush),
        .m_axis_tvalid                   (m_tvalid),
        .m_axis_tready                   (m_tready),
        .m_axis_tdata_programID          (m_id),
        .m_axis_tlast                    (m_tlast),
        .m_axis_batch_size               (m_size),
        .m_axis_batch_read_dependencies  (m_rd),
        .m_axis_batch_write_dependencies (m_wr),
        .batch_completed                 (completed),
        .batches_formed                  (formed),
        .batch_timeouts                  (timeouts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tready;
        logic        valid;
        logic [63:0] id;
        logic        last;
        logic        sready;
        logic        done;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] id, input logic [1023:0] rd,
                        input logic [1023:0] wr, input logic fl);
        check("push_sready", 64'(s_tready), 64'd1);
        s_tvalid = 1'b1;
        s_id     = id;
        s_rd     = rd;
        s_wr     = wr;
        flush    = fl;
        step();
        s_tvalid = 1'b0;
        flush    = 1'b0;
        s_rd     = '0;
        s_wr     = '0;
    endtask

    // Drains a batch with tready held high; IDs are expected to run base..base+n-1.
    task automatic expect_drain(input int n, input logic [63:0] base);
        int w;
        w = 0;
        m_tready = 1'b1;
        while (!m_tvalid && w < 400) begin
            step();
            w++;
        end
        if (!m_tvalid) begin
            checks++;
            errors++;
            $display("FAIL drain_start: got valid=0 expected=1 within 400 cycles");
            return;
        end
        for (int i = 0; i < n; i++) begin
            check("beat_valid", 64'(m_tvalid), 64'd1);
            check("beat_id", m_id, base + 64'(i));
            check("beat_last", 64'(m_tlast), 64'(i == n - 1));
            check("beat_size", 64'(m_size), 64'(n));
            check("drain_sready", 64'(s_tready), 64'd0);
            step();
        end
        check("done_pulse", 64'(completed), 64'd1);
        check("done_valid", 64'(m_tvalid), 64'd0);
        step();
        check("done_pulse_end", 64'(completed), 64'd0);
        check("sready_back", 64'(s_tready), 64'd1);
    endtask

    initial begin
        int cyc;
        logic idle_ok;

        vecs[0] = '{tready: 1'b1, valid: 1'b1, id: 64'd301, last: 1'b0, sready: 1'b0, done: 1'b0};
        vecs[1] = '{tready: 1'b0, valid: 1'b1, id: 64'd302, last: 1'b0, sready: 1'b0, done: 1'b0};
        vecs[2] = '{tready: 1'b1, valid: 1'b1, id: 64'd302, last: 1'b0, sready: 1'b0, done: 1'b0};
        vecs[3] = '{tready: 1'b0, valid: 1'b1, id: 64'd303, last: 1'b1, sready: 1'b0, done: 1'b0};
        vecs[4] = '{tready: 1'b1, valid: 1'b1, id: 64'd303, last: 1'b1, sready: 1'b0, done: 1'b0};
        vecs[5] = '{tready: 1'b1, valid: 1'b0, id: 64'd0,   last: 1'b0, sready: 1'b0, done: 1'b1};
        vecs[6] = '{tready: 1'b1, valid: 1'b0, id: 64'd0,   last: 1'b0, sready: 1'b1, done: 1'b0};

        rst = 1'b1; s_tvalid = 1'b0; s_id = '0; s_rd = '0; s_wr = '0;
        flush = 1'b0; m_tready = 1'b1;
        step();
        step();
        check("rst_sready", 64'(s_tready), 64'd1);
        check("rst_mvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_completed", 64'(completed), 64'd0);
        check("rst_id", m_id, 64'd0);
        check("rst_size", 64'(m_size), 64'd0);
        check("rst_rd", m_rd[63:0], 64'd0);
        check("rst_formed", 64'(formed), 64'd0);
        check("rst_timeouts", 64'(timeouts), 64'd0);
        rst = 1'b0;

        // Full batch of 16 back-to-back
        for (int i = 1; i <= 16; i++) push(64'(i), '0, '0, 1'b0);
        check("full_sready_low", 64'(s_tready), 64'd0);
        check("full_mvalid", 64'(m_tvalid), 64'd1);
        expect_drain(16, 64'd1);
        check("full_formed", 64'(formed), 64'd1);
        check("full_timeouts", 64'(timeouts), 64'd0);

        // Timeout close of a 3-entry batch: first beat 256 edges after the first accept
        push(64'd101, 1024'h1, 1024'h400, 1'b0);
        push(64'd102, 1024'h2, 1024'h800, 1'b0);
        push(64'd103, 1024'h4, 1024'h1000, 1'b0);
        cyc = 2;
        while (!m_tvalid && cyc < 400) begin
            step();
            cyc++;
        end
        check("tmo_latency", 64'(cyc), 64'd256);
        check("tmo_rd_union", m_rd[63:0], 64'h7);
        check("tmo_wr_union", m_wr[63:0], 64'h1C00);
        check("tmo_count", 64'(timeouts), 64'd1);
        expect_drain(3, 64'd101);

        // Flush closes a 2-entry batch; flush when empty is ignored
        push(64'd201, '0, '0, 1'b0);
        push(64'd202, '0, '0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_mvalid", 64'(m_tvalid), 64'd1);
        expect_drain(2, 64'd201);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (m_tvalid || completed) idle_ok = 1'b0;
            step();
        end
        check("empty_flush_idle", 64'(idle_ok), 64'd1);
        check("flush_formed", 64'(formed), 64'd3);
        check("flush_timeouts", 64'(timeouts), 64'd1);

        // Stalled drain, table-driven; third accept coincides with flush
        push(64'd301, '0, '0, 1'b0);
        push(64'd302, '0, '0, 1'b0);
        push(64'd303, '0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            m_tready = vecs[i].tready;
            check($sformatf("vec%0d_valid", i), 64'(m_tvalid), 64'(vecs[i].valid));
            check($sformatf("vec%0d_id", i), m_id, vecs[i].id);
            check($sformatf("vec%0d_last", i), 64'(m_tlast), 64'(vecs[i].last));
            check($sformatf("vec%0d_sready", i), 64'(s_tready), 64'(vecs[i].sready));
            check($sformatf("vec%0d_done", i), 64'(completed), 64'(vecs[i].done));
            step();
        end
        m_tready = 1'b1;

        // Reset in the middle of a 5-entry drain
        for (int i = 0; i < 4; i++) push(64'(501 + i), 1024'h1 << 40, 1024'h1 << 1000, 1'b0);
        push(64'd505, 1024'h1 << 40, 1024'h1 << 1000, 1'b1);
        check("mid_size", 64'(m_size), 64'd5);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 64'(m_tvalid), 64'd0);
        check("mid_rst_id", m_id, 64'd0);
        check("mid_rst_size", 64'(m_size), 64'd0);
        check("mid_rst_completed", 64'(completed), 64'd0);
        check("mid_rst_sready", 64'(s_tready), 64'd1);
        step();
        check("mid_rst_no_pulse", 64'(completed), 64'd0);
        push(64'd601, 1024'h8, '0, 1'b1);
        check("post_rst_size", 64'(m_size), 64'd1);
        check("post_rst_rd", m_rd[63:0], 64'h8);
        check("post_rst_wr_hi", m_wr[1023:960], 64'd0);
        check("post_rst_rd_hi", m_rd[63:0] & (64'h1 << 40), 64'd0);
        expect_drain(1, 64'd601);

        // 16th accept coincides with timer == TIMEOUT_CYCLES-1: full close wins
        for (int i = 0; i < 15; i++) push(64'(701 + i), '0, '0, 1'b0);
        cyc = 14;
        while (cyc < 255) begin
            step();
            cyc++;
        end
        check("coinc_no_early_close", 64'(m_tvalid), 64'd0);
        push(64'd716, '0, '0, 1'b0);
        check("coinc_valid", 64'(m_tvalid), 64'd1);
        expect_drain(16, 64'd701);
        check("coinc_timeouts", 64'(timeouts), 64'd0);
        check("coinc_formed", 64'(formed), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
